load_use_scoreboard: RTL and testbench

- Tracks the destination registers of the three instructions in flight downstream of decode (Ex, Ex2Mem, Mem2Wb).
- Stalls decode whenever a source operand's producer has not yet produced forwardable data.
- Sits beside the forwarding unit, on the other side of the same operand-bypass interface:
  - the forwarding unit consumes in-flight results;
  - this block decides when those results are not yet consumable and holds issue.
- Also keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/load_use_scoreboard_pkg.sv | 49 ++++
 rtl/load_use_scoreboard_if.sv | 34 +++
 rtl/load_use_scoreboard_match.sv | 30 +++
 rtl/load_use_scoreboard.sv | 88 ++++++++
 tb/tb_load_use_scoreboard.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_use_scoreboard_pkg.sv
// Shared definitions for the load-use scoreboard: issue-kind encodings,
// shadow-pipeline entry layout and the register-address width.
package load_use_scoreboard_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int NUM_ENTRIES = 3;
  localparam int IDX_EX      = 0;
  localparam int IDX_EX2MEM  = 1;
  localparam int IDX_MEM2WB  = 2;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'b00,
    KIND_LOAD   = 2'b01,
    KIND_MULDIV = 2'b10
  } issue_kind_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    issue_kind_e           kind;
    logic                  ready;
  } sb_entry_t;

  localparam int ENTRY_W = $bits(sb_entry_t);

  localparam sb_entry_t ENTRY_INVALID = '{
    valid: 1'b0,
    rd:    {REG_ADDR_W{1'b0}},
    kind:  KIND_ALU,
    ready: 1'b0
  };

  // The reserved encoding folds into ALU; only ALU results are forwardable at once.
  function automatic sb_entry_t make_entry(input logic                  valid,
                                           input logic [REG_ADDR_W-1:0] rd,
                                           input logic [1:0]            raw_kind);
    sb_entry_t e;
    e.valid = valid;
    e.rd    = rd;
    case (raw_kind)
      2'b01:   e.kind = KIND_LOAD;
      2'b10:   e.kind = KIND_MULDIV;
      default: e.kind = KIND_ALU;
    endcase
    e.ready = (e.kind == KIND_ALU);
    return e;
  endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// Decode-side issue/operand signals seen by the scoreboard, plus its stall
// and performance-count outputs.
interface load_use_scoreboard_if #(
  parameter int XLEN_CNT = 32
);
  import load_use_scoreboard_pkg::*;

  logic                  AdvanceIn;
  logic                  IssueValidIn;
  logic [REG_ADDR_W-1:0] IssueRdAddrIn;
  logic                  IssueRdWriteEnableIn;
  logic [1:0]            IssueKindIn;
  logic [REG_ADDR_W-1:0] Rs1AddrIdIn;
  logic [REG_ADDR_W-1:0] Rs2AddrIdIn;
  logic                  Rs1UsedIn;
  logic                  Rs2UsedIn;
  logic                  FlushIn;
  logic                  MulDivDoneIn;
  logic                  StallOut;
  logic [XLEN_CNT-1:0]   StallCycleCountOut;

  modport master (
    output AdvanceIn, IssueValidIn, IssueRdAddrIn, IssueRdWriteEnableIn, IssueKindIn,
           Rs1AddrIdIn, Rs2AddrIdIn, Rs1UsedIn, Rs2UsedIn, FlushIn, MulDivDoneIn,
    input  StallOut, StallCycleCountOut
  );

  modport slave (
    input  AdvanceIn, IssueValidIn, IssueRdAddrIn, IssueRdWriteEnableIn, IssueKindIn,
           Rs1AddrIdIn, Rs2AddrIdIn, Rs1UsedIn, Rs2UsedIn, FlushIn, MulDivDoneIn,
    output StallOut, StallCycleCountOut
  );

endinterface

// File: rtl/load_use_scoreboard_match.sv
// Per-source hazard check: consults only the youngest in-flight producer of
// the source register, mirroring the forwarding unit's priority.
module scoreboard_match
  import load_use_scoreboard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0]        src_addr_i,
  input  logic                         src_used_i,
  input  sb_entry_t [NUM_ENTRIES-1:0]  entries_i,
  output logic                         blocked_o
);

  logic producer_ready_s;

  // Youngest matching entry decides; no match means the regfile value is good.
  always_comb begin
    producer_ready_s = 1'b1;
    if (entries_i[IDX_EX].valid && (entries_i[IDX_EX].rd == src_addr_i)) begin
      producer_ready_s = entries_i[IDX_EX].ready;
    end else if (entries_i[IDX_EX2MEM].valid && (entries_i[IDX_EX2MEM].rd == src_addr_i)) begin
      producer_ready_s = entries_i[IDX_EX2MEM].ready;
    end else if (entries_i[IDX_MEM2WB].valid && (entries_i[IDX_MEM2WB].rd == src_addr_i)) begin
      producer_ready_s = entries_i[IDX_MEM2WB].ready;
    end else begin
      producer_ready_s = 1'b1;
    end
  end

  assign blocked_o = src_used_i & (src_addr_i != {REG_ADDR_W{1'b0}}) & ~producer_ready_s;

endmodule

// File: rtl/load_use_scoreboard.sv
// Shadow pipeline of in-flight destinations (Ex, Ex2Mem, Mem2Wb) that holds
// decode while a source's producer is not yet forwardable; counts stall cycles.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int XLEN_CNT = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  load_use_scoreboard_if.slave    sb
);

  localparam logic [NUM_REGS-1:0] TRACKED_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};
  localparam logic [XLEN_CNT-1:0] CNT_MAX      = {XLEN_CNT{1'b1}};

  sb_entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
  logic [XLEN_CNT-1:0]         cnt_q, cnt_d;

  sb_entry_t ex_upd_s;
  sb_entry_t mem2wb_in_s;
  sb_entry_t new_entry_s;
  logic      blk_rs1_s;
  logic      blk_rs2_s;
  logic      stall_s;
  logic      create_s;

  scoreboard_match u_match_rs1 (
    .src_addr_i (sb.Rs1AddrIdIn),
    .src_used_i (sb.Rs1UsedIn),
    .entries_i  (ent_q),
    .blocked_o  (blk_rs1_s)
  );

  scoreboard_match u_match_rs2 (
    .src_addr_i (sb.Rs2AddrIdIn),
    .src_used_i (sb.Rs2UsedIn),
    .entries_i  (ent_q),
    .blocked_o  (blk_rs2_s)
  );

  assign stall_s  = sb.IssueValidIn & (blk_rs1_s | blk_rs2_s);
  assign create_s = sb.IssueValidIn & sb.IssueRdWriteEnableIn & TRACKED_MASK[sb.IssueRdAddrIn]
                  & ~stall_s & ~sb.FlushIn;

  // Shadow-pipeline next state; ready bits update whether or not the pipe advances.
  always_comb begin
    ent_d       = ent_q;
    ex_upd_s    = ent_q[IDX_EX];
    ex_upd_s.ready = ent_q[IDX_EX].ready
                   | ((ent_q[IDX_EX].kind == KIND_MULDIV) & sb.MulDivDoneIn);
    mem2wb_in_s = ent_q[IDX_EX2MEM];
    mem2wb_in_s.ready = ent_q[IDX_EX2MEM].ready | (ent_q[IDX_EX2MEM].kind == KIND_LOAD);
    new_entry_s = make_entry(create_s, sb.IssueRdAddrIn, sb.IssueKindIn);
    if (sb.AdvanceIn) begin
      ent_d[IDX_MEM2WB] = mem2wb_in_s;
      ent_d[IDX_EX2MEM] = ex_upd_s;
      ent_d[IDX_EX]     = new_entry_s;
    end else begin
      ent_d[IDX_EX]     = ex_upd_s;
    end
  end

  // Saturating stall counter; a held pipe does not count as a lost issue slot.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_s && sb.AdvanceIn && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + XLEN_CNT'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= {NUM_ENTRIES{ENTRY_INVALID}};
      cnt_q <= {XLEN_CNT{1'b0}};
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign sb.StallOut           = stall_s;
  assign sb.StallCycleCountOut = cnt_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Scenario bench for load_use_scoreboard: per-cycle expected stall values are
// queued as stimulus is applied and popped when the outputs are sampled.
module tb_load_use_scoreboard;
  import load_use_scoreboard_pkg::*;

  typedef struct {
    logic       adv;
    logic       iv;
    logic [4:0] rd;
    logic       we;
    logic [1:0] kind;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       fl;
    logic       mdd;
    logic       exp_stall;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  load_use_scoreboard_if #(.XLEN_CNT(32)) bus ();
  load_use_scoreboard_if #(.XLEN_CNT(2))  bus_s ();

  load_use_scoreboard #(.XLEN_CNT(32), .NUM_REGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus.slave)
  );

  load_use_scoreboard #(.XLEN_CNT(2), .NUM_REGS(32)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus_s.slave)
  );

  function automatic stim_t issue(input logic adv, input logic [4:0] rd, input logic [1:0] kind,
                                  input logic exp_s);
    stim_t s;
    s = '{adv: adv, iv: 1'b1, rd: rd, we: 1'b1, kind: kind, rs1: 5'd0, rs2: 5'd0,
          u1: 1'b0, u2: 1'b0, fl: 1'b0, mdd: 1'b0, exp_stall: exp_s};
    return s;
  endfunction

  function automatic stim_t use_rs(input logic adv, input logic [4:0] rs1, input logic u1,
                                   input logic [4:0] rs2, input logic u2, input logic mdd,
                                   input logic fl, input logic exp_s);
    stim_t s;
    s = '{adv: adv, iv: 1'b1, rd: 5'd20, we: 1'b1, kind: 2'b00, rs1: rs1, rs2: rs2,
          u1: u1, u2: u2, fl: fl, mdd: mdd, exp_stall: exp_s};
    return s;
  endfunction

  function automatic stim_t idle(input logic adv);
    stim_t s;
    s = '{adv: adv, iv: 1'b0, rd: 5'd0, we: 1'b0, kind: 2'b00, rs1: 5'd0, rs2: 5'd0,
          u1: 1'b0, u2: 1'b0, fl: 1'b0, mdd: 1'b0, exp_stall: 1'b0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.AdvanceIn = s.adv;              bus_s.AdvanceIn = s.adv;
    bus.IssueValidIn = s.iv;            bus_s.IssueValidIn = s.iv;
    bus.IssueRdAddrIn = s.rd;           bus_s.IssueRdAddrIn = s.rd;
    bus.IssueRdWriteEnableIn = s.we;    bus_s.IssueRdWriteEnableIn = s.we;
    bus.IssueKindIn = s.kind;           bus_s.IssueKindIn = s.kind;
    bus.Rs1AddrIdIn = s.rs1;            bus_s.Rs1AddrIdIn = s.rs1;
    bus.Rs2AddrIdIn = s.rs2;            bus_s.Rs2AddrIdIn = s.rs2;
    bus.Rs1UsedIn = s.u1;               bus_s.Rs1UsedIn = s.u1;
    bus.Rs2UsedIn = s.u2;               bus_s.Rs2UsedIn = s.u2;
    bus.FlushIn = s.fl;                 bus_s.FlushIn = s.fl;
    bus.MulDivDoneIn = s.mdd;           bus_s.MulDivDoneIn = s.mdd;
  endtask

  task automatic apply(input stim_t s);
    drive(s);
    exp_q.push_back(s.exp_stall);
  endtask

  task automatic do_reset();
    drive(idle(1'b0));
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (bus.StallOut !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", bus.StallOut);
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", bus.StallCycleCountOut);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    stim_t t[$];
    logic  e;
    do_reset();
    t.push_back(issue(1'b1, 5'd5, KIND_LOAD, 1'b0));
    t.push_back(use_rs(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    t.push_back(idle(1'b1));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.StallOut !== e) begin
        n_fail++; $display("FAIL load_use_stall c%0d: got %b want %b", i, bus.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd2) begin
      n_fail++; $display("FAIL load_use_count: got %0d want 2", bus.StallCycleCountOut);
    end
  endtask

  task automatic test_back_to_back_alu();
    stim_t t[$];
    logic  e;
    do_reset();
    t.push_back(issue(1'b1, 5'd7, KIND_ALU, 1'b0));
    t.push_back(use_rs(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    t.push_back(use_rs(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    t.push_back(issue(1'b1, 5'd7, 2'b11, 1'b0));
    t.push_back(use_rs(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.StallOut !== e) begin
        n_fail++; $display("FAIL alu_b2b_stall c%0d: got %b want %b", i, bus.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd0) begin
      n_fail++; $display("FAIL alu_b2b_count: got %0d want 0", bus.StallCycleCountOut);
    end
  endtask

  task automatic test_muldiv();
    stim_t t[$];
    logic  e;
    do_reset();
    t.push_back(issue(1'b1, 5'd9, KIND_MULDIV, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      t.push_back(use_rs(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, (k == 4), 1'b0, 1'b1));
    end
    t.push_back(use_rs(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    t.push_back(use_rs(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.StallOut !== e) begin
        n_fail++; $display("FAIL muldiv_stall c%0d: got %b want %b", i, bus.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd0) begin
      n_fail++; $display("FAIL muldiv_count: got %0d want 0", bus.StallCycleCountOut);
    end
  endtask

  task automatic test_youngest_wins();
    stim_t t[$];
    logic  e;
    // Youngest unready load behind an older ready pair, then an unused source.
    do_reset();
    t.push_back(issue(1'b1, 5'd3, KIND_LOAD, 1'b0));
    t.push_back(issue(1'b1, 5'd3, KIND_ALU, 1'b0));
    t.push_back(issue(1'b1, 5'd3, KIND_LOAD, 1'b0));
    t.push_back(use_rs(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b0, 5'd3, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.StallOut !== e) begin
        n_fail++; $display("FAIL youngest_unready c%0d: got %b want %b", i, bus.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
    t.delete();
    do_reset();
    t.push_back(issue(1'b1, 5'd3, KIND_LOAD, 1'b0));
    t.push_back(issue(1'b1, 5'd3, KIND_LOAD, 1'b0));
    t.push_back(issue(1'b1, 5'd3, KIND_ALU, 1'b0));
    t.push_back(use_rs(1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.StallOut !== e) begin
        n_fail++; $display("FAIL youngest_ready c%0d: got %b want %b", i, bus.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_x0_and_flush();
    stim_t t[$];
    logic  e;
    do_reset();
    t.push_back(issue(1'b1, 5'd0, KIND_LOAD, 1'b0));
    t.push_back(use_rs(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    t.push_back(issue(1'b1, 5'd4, KIND_LOAD, 1'b0));
    // Flushed load to x10 while stalled on x4: counted, no entry.
    t.push_back('{adv: 1'b1, iv: 1'b1, rd: 5'd10, we: 1'b1, kind: 2'b01, rs1: 5'd4, rs2: 5'd0,
                  u1: 1'b1, u2: 1'b0, fl: 1'b1, mdd: 1'b0, exp_stall: 1'b1});
    t.push_back(use_rs(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    t.push_back('{adv: 1'b1, iv: 1'b1, rd: 5'd11, we: 1'b1, kind: 2'b01, rs1: 5'd0, rs2: 5'd0,
                  u1: 1'b0, u2: 1'b0, fl: 1'b1, mdd: 1'b0, exp_stall: 1'b0});
    t.push_back(use_rs(1'b1, 5'd11, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.StallOut !== e) begin
        n_fail++; $display("FAIL x0_flush_stall c%0d: got %b want %b", i, bus.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd1) begin
      n_fail++; $display("FAIL flush_count: got %0d want 1", bus.StallCycleCountOut);
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t t[$];
    logic  e;
    do_reset();
    t.push_back(issue(1'b1, 5'd1, KIND_LOAD, 1'b0));
    t.push_back(issue(1'b1, 5'd2, KIND_LOAD, 1'b0));
    t.push_back(issue(1'b1, 5'd13, KIND_LOAD, 1'b0));
    t.push_back(use_rs(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b0, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.StallOut !== e) begin
        n_fail++; $display("FAIL pre_reset_stall c%0d: got %b want %b", i, bus.StallOut, e);
      end
      if (i < t.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd1) begin
      n_fail++; $display("FAIL pre_reset_count: got %0d want 1", bus.StallCycleCountOut);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.StallOut !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_stall: got %b want 0", bus.StallOut);
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_count: got %0d want 0", bus.StallCycleCountOut);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.StallOut !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_stall: got %b want 0", bus.StallOut);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    stim_t t[$];
    logic  e;
    do_reset();
    t.push_back(issue(1'b1, 5'd5, KIND_LOAD, 1'b0));
    t.push_back(use_rs(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus_s.StallOut !== e) begin
        n_fail++; $display("FAIL sat_pre_stall c%0d: got %b want %b", i, bus_s.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus_s.StallCycleCountOut !== 2'd2) begin
      n_fail++; $display("FAIL sat_pre_count: got %0d want 2", bus_s.StallCycleCountOut);
    end
    // A mul/div that never completes stays unready through all three stages.
    t.delete();
    t.push_back(issue(1'b1, 5'd9, KIND_MULDIV, 1'b0));
    t.push_back(use_rs(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    t.push_back(use_rs(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus_s.StallOut !== e) begin
        n_fail++; $display("FAIL sat_stall c%0d: got %b want %b", i, bus_s.StallOut, e);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus_s.StallCycleCountOut !== 2'd3) begin
      n_fail++; $display("FAIL sat_count: got %0d want 3", bus_s.StallCycleCountOut);
    end
    n_cmp++;
    if (bus.StallCycleCountOut !== 32'd5) begin
      n_fail++; $display("FAIL wide_count: got %0d want 5", bus.StallCycleCountOut);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(idle(1'b0));
    test_reset();
    test_load_use();
    test_back_to_back_alu();
    test_muldiv();
    test_youngest_wins();
    test_x0_and_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
